// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port over a word-wide sync RAM.
// Big-endian lanes, sub-word stores done as read-modify-write.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    RESP
  } state_t;

  state_t state;

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  range_err;
  logic                  align_err;
  logic                  size_err;
  logic                  req_err;
  logic                  accept;

  logic                  l_we;
  logic [1:0]            l_size;
  logic                  l_signed;
  logic [1:0]            l_lane;
  logic [DEPTH_LOG2-1:0] l_idx;
  logic [31:0]           l_wdata;
  logic                  l_err;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic [31:0]           load_data;
  logic                  wr_en;

  // Modular subtraction: addresses below the base wrap high and fail range.
  assign off       = req_addr - BASE_ADDR;
  assign req_idx   = off[DEPTH_LOG2+1:2];
  assign range_err = |off[31:DEPTH_LOG2+2];
  assign size_err  = (req_size == 2'b11);
  assign align_err = ((req_size == 2'b01) && off[0]) ||
                     ((req_size == 2'b10) && (off[1:0] != 2'b00));
  assign req_err   = range_err | align_err | size_err;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign wr_en     = (state == MERGE);

  // RAM has no reset; the write only happens while MERGE is the live state,
  // so an asynchronous reset in MERGE drops the whole write.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[l_idx] <= merged;
    if (accept)
      rd_word <= mem[req_idx];
  end

  logic [4:0] bsh;
  logic [4:0] hsh;

  assign bsh = {~l_lane, 3'b000};
  assign hsh = {~l_lane[1], 4'b0000};

  always_comb begin
    merged = rd_word;
    unique case (1'b1)
      (l_size == 2'b00): merged[bsh +: 8]  = l_wdata[7:0];
      (l_size == 2'b01): merged[hsh +: 16] = l_wdata[15:0];
      (l_size == 2'b10): merged            = l_wdata;
      default:           merged            = rd_word;
    endcase
  end

  logic [7:0]  lb;
  logic [15:0] lh;

  assign lb = rd_word[bsh +: 8];
  assign lh = rd_word[hsh +: 16];

  always_comb begin
    load_data = 32'h0;
    unique case (1'b1)
      (l_size == 2'b00): load_data = {{24{l_signed & lb[7]}}, lb};
      (l_size == 2'b01): load_data = {{16{l_signed & lh[15]}}, lh};
      (l_size == 2'b10): load_data = rd_word;
      default:           load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      l_we     <= 1'b0;
      l_size   <= 2'b00;
      l_signed <= 1'b0;
      l_lane   <= 2'b00;
      l_idx    <= '0;
      l_wdata  <= 32'h0;
      l_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            l_we     <= req_we;
            l_size   <= req_size;
            l_signed <= req_signed;
            l_lane   <= off[1:0];
            l_idx    <= req_idx;
            l_wdata  <= req_wdata;
            l_err    <= req_err;
            state    <= (req_we && !req_err) ? MERGE : RESP;
          end
        end
        MERGE: state <= RESP;
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response fields derive only from registers, so they hold under backpressure.
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & l_err;
  assign resp_rdata = (resp_valid && !l_we && !l_err) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
// Also covers backpressure, mid-store reset and back-to-back traffic.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam int unsigned SPAN = 4 * 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  byte unsigned mdl [int unsigned];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_LOG2(11),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] o;
    o = addr - BASE;
    if (size == 2'd3) return 1'b1;
    if (o >= SPAN) return 1'b1;
    if (size == 2'd1 && o % 2 != 0) return 1'b1;
    if (size == 2'd2 && o % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] addr);
    logic [31:0] o;
    longint v;
    int n;
    o = addr - BASE;
    n = nbytes(size);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v * 256 + (mdl.exists(o + i) ? mdl[o + i] : 0);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
    logic [31:0] o;
    int n;
    o = addr - BASE;
    n = nbytes(size);
    for (int i = 0; i < n; i++)
      mdl[o + i] = byte'((wd >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  task automatic xact(input bit we, input logic [1:0] size, input bit sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input bit intrude,
                      output logic [31:0] rd, output logic er);
    int lat;
    int exp_lat;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = (we && !mdl_err(size, addr)) ? 2 : 1;
    check("latency", lat, exp_lat);
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) return;
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = BASE + 32'd60;
        req_wdata = 32'h0BAD0BAD;
      end
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, rd);
      check("bp_err", {31'b0, resp_err}, {31'b0, er});
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic do_op(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd);
    logic er;
    bit e;
    logic [31:0] exp;
    e = mdl_err(size, addr);
    exp = (we || e) ? 32'h0 : mdl_load(size, sgn, addr);
    xact(we, size, sgn, addr, wd, hold, 1'b0, rd, er);
    check(we ? "st_rdata" : "ld_rdata", rd, exp);
    check("err", {31'b0, er}, {31'b0, e});
    if (we && !e) mdl_store(size, addr, wd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] old;
    int n;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;

    do_op(1'b1, 2'd2, 1'b0, BASE, 32'hDEADBEEF, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE, 32'h0, 0, rd);
    check("word_dir", rd, 32'hDEADBEEF);
    for (int w = 1; w < 16; w++)
      do_op(1'b1, 2'd2, 1'b0, BASE + 4 * w, $urandom, 0, rd);

    do_op(1'b1, 2'd0, 1'b0, BASE + 1, 32'hFFFFFF12, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE, 32'h0, 0, rd);
    check("sb_dir", rd, 32'hDE12BEEF);
    do_op(1'b1, 2'd1, 1'b0, BASE + 2, 32'h00003456, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE, 32'h0, 0, rd);
    check("sh_dir", rd, 32'hDE123456);
    do_op(1'b0, 2'd0, 1'b1, BASE, 32'h0, 0, rd);
    check("lb_s_dir", rd, 32'hFFFFFFDE);
    do_op(1'b0, 2'd0, 1'b0, BASE, 32'h0, 0, rd);
    check("lb_u_dir", rd, 32'h000000DE);
    do_op(1'b0, 2'd1, 1'b1, BASE + 2, 32'h0, 0, rd);
    check("lh_s_dir", rd, 32'h00003456);

    do_op(1'b0, 2'd2, 1'b0, BASE + 2, 32'h0, 0, rd);
    do_op(1'b1, 2'd1, 1'b0, BASE + 3, 32'h0000FFFF, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE, 32'h0, 0, rd);
    check("mis_store_nochg", rd, 32'hDE123456);
    do_op(1'b0, 2'd2, 1'b0, 32'h0FFFFFFC, 32'h0, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE + 32'h2000, 32'h0, 0, rd);
    do_op(1'b0, 2'd3, 1'b0, BASE, 32'h0, 0, rd);
    do_op(1'b1, 2'd2, 1'b0, BASE + 32'h1FFC, 32'hC0FFEE11, 0, rd);
    do_op(1'b0, 2'd2, 1'b0, BASE + 32'h1FFC, 32'h0, 0, rd);
    check("last_word", rd, 32'hC0FFEE11);

    old = mdl_load(2'd2, 1'b0, BASE + 60);
    xact(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, 5, 1'b1, rd, er);
    check("bp_data", rd, mdl_load(2'd2, 1'b0, BASE + 4));
    do_op(1'b0, 2'd2, 1'b0, BASE + 60, 32'h0, 0, rd);
    check("bp_ignored", rd, old);

    old = mdl_load(2'd2, 1'b0, BASE + 4);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = BASE + 4;
    req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_req_ready", {31'b0, req_ready}, 32'd1);
    check("mr_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mr_rdata", resp_rdata, 32'h0);
    check("mr_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, 0, 1'b0, rd, er);
    check("mr_word", {31'b0, rd == old || rd == 32'hAABBCCDD}, 32'd1);
    mdl_store(2'd2, BASE + 4, rd);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = BASE + 8;
    req_wdata = 32'h5A5AA5A5;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_st_lat", n, 2);
    mdl_store(2'd2, BASE + 8, 32'h5A5AA5A5);
    resp_ready = 1'b1;
    req_we     = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_gap_valid", {31'b0, resp_valid}, 32'd0);
    check("b2b_gap_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_ld_valid", {31'b0, resp_valid}, 32'd1);
    check("b2b_ld_data", resp_rdata, 32'h5A5AA5A5);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = BASE + $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) sz = 2'd3;
      if ($urandom_range(0, 24) == 0) a = BASE - 32'($urandom_range(1, 16));
      if ($urandom_range(0, 24) == 0) a = BASE + SPAN + 32'($urandom_range(0, 64));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            $urandom, $urandom_range(0, 2), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
